// File: rtl/nems_cfg_pkg.sv
// Shared types and helpers for the NEMS relay configuration sequencer.
package nems_cfg_pkg;

    // Default crossbar geometry of a CLB tile, shared with the tile top.
    localparam int NEMS_NROWS = 30;
    localparam int NEMS_NCOLS = 29;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PULSE,
        ST_SETTLE,
        ST_DONE
    } nems_cfg_state_t;

    // A column window is unusable if it is reversed or runs past the last column.
    function automatic logic cfg_range_bad(input int unsigned first,
                                           input int unsigned last,
                                           input int unsigned ncols);
        return (first > last) || (last >= ncols);
    endfunction

endpackage

// File: rtl/nems_cfg_timer.sv
// Loadable down-counter that times both the coincidence pulse and the settle wait.
// expire_o is high during the last cycle of a loaded interval.
module nems_cfg_timer
    import nems_cfg_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expire_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TW'(1));

endmodule

// File: rtl/nems_cfg_sequencer.sv
// Column-by-column programming engine for the NEMS relay select lines.
// Row data is shifted into a shadow register, then driven together with a
// one-hot column select for a timed pulse, followed by a settle interval.
module nems_cfg_sequencer
    import nems_cfg_pkg::*;
#(
    parameter int NROWS = NEMS_NROWS,
    parameter int NCOLS = NEMS_NCOLS,
    parameter int TW    = 8,
    parameter int CW    = $clog2(NCOLS)
) (
    input  logic             cfg_clk,
    input  logic             cfg_rst_n,
    input  logic             cfg_start,
    input  logic [CW-1:0]    cfg_col_first,
    input  logic [CW-1:0]    cfg_col_last,
    input  logic [TW-1:0]    cfg_pulse_cyc,
    input  logic [TW-1:0]    cfg_settle_cyc,
    input  logic             cfg_scan_en,
    input  logic             cfg_scan_in,
    output logic             cfg_scan_out,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [NROWS-1:0] cfgrows,
    output logic [NCOLS-1:0] cfgcols
);

    localparam int CNTW = $clog2(NROWS + 1);

    nems_cfg_state_t  state_q, state_d;
    logic [NROWS-1:0] shadow_q, shadow_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    col_last_q, col_last_d;
    logic [TW-1:0]    pulse_q, pulse_d;
    logic [TW-1:0]    settle_q, settle_d;
    logic             err_q, err_d;
    logic [NROWS-1:0] rows_q, rows_d;
    logic [NCOLS-1:0] cols_q, cols_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expire;
    logic             advance;
    logic [TW-1:0]    pulse_eff;

    // A zero pulse length still produces one pulse cycle.
    assign pulse_eff = (pulse_q == '0) ? TW'(1) : pulse_q;

    nems_cfg_timer #(.TW(TW)) u_timer (
        .clk_i      (cfg_clk),
        .rst_ni     (cfg_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        col_last_d = col_last_q;
        pulse_d    = pulse_q;
        settle_d   = settle_q;
        err_d      = err_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        advance    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    col_last_d = cfg_col_last;
                    pulse_d    = cfg_pulse_cyc;
                    settle_d   = cfg_settle_cyc;
                    if (cfg_range_bad(32'(cfg_col_first), 32'(cfg_col_last), 32'(NCOLS))) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        col_d   = cfg_col_first;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (cfg_scan_en) begin
                    shadow_d = {shadow_q[NROWS-2:0], cfg_scan_in};
                    cnt_d    = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(NROWS - 1)) begin
                        state_d  = ST_PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = pulse_eff;
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_expire) begin
                    if (settle_q != '0) begin
                        state_d  = ST_SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = settle_q;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (col_q == col_last_q) begin
                state_d = ST_DONE;
            end else begin
                col_d   = col_q + CW'(1);
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
        end

        // Selects are decoded from the next state so they line up with PULSE.
        rows_d = (state_d == ST_PULSE) ? shadow_d : '0;
        cols_d = (state_d == ST_PULSE) ? (NCOLS'(1) << col_d) : '0;
        busy_d = (state_d == ST_LOAD) || (state_d == ST_PULSE) || (state_d == ST_SETTLE);
        done_d = (state_d == ST_DONE);
    end

    // State, shadow, counters and outputs; reset clears everything.
    always_ff @(posedge cfg_clk) begin
        if (!cfg_rst_n) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            cnt_q      <= '0;
            col_q      <= '0;
            col_last_q <= '0;
            pulse_q    <= '0;
            settle_q   <= '0;
            err_q      <= 1'b0;
            rows_q     <= '0;
            cols_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            col_last_q <= col_last_d;
            pulse_q    <= pulse_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_scan_out = shadow_q[NROWS-1];
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign cfgrows      = rows_q;
    assign cfgcols      = cols_q;

endmodule
